// File: rtl/fpadd_scheduler.sv
// ============================================================================
// Module   : fpadd_scheduler
// Purpose  : Round-robin scheduler sharing one multi-cycle fpadd unit among
//            NUM_REQ requesters, one operation in flight at a time.
//            Optional WAIT-state watchdog enabled by macro FPADD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpadd_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
`ifdef FPADD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [31:0]             rsp_sum,
    output logic                    fpa_start,
    output logic [31:0]             fpa_a,
    output logic [31:0]             fpa_b,
    input  logic [31:0]             fpa_sum,
    input  logic                    fpa_done,
    output logic                    busy,
`ifdef FPADD_TIMEOUT_EN
    output logic                    timeout_err,
`endif
    output logic [CNT_W-1:0]        op_count
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
`ifdef FPADD_TIMEOUT_EN
    localparam int          c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_grant;
    logic [31:0]          r_fpa_a;
    logic [31:0]          r_fpa_b;
    logic [31:0]          r_rsp_sum;
    logic [CNT_W-1:0]     r_op_count;

    logic [c_IDX_W-1:0]   w_grant;
    logic [c_IDX_W-1:0]   w_cand;
    logic                 w_any;
    logic [NUM_REQ-1:0]   w_grant_oh;
    logic [NUM_REQ-1:0]   w_resp_oh;
    logic [31:0]          w_sel_a;
    logic [31:0]          w_sel_b;
    logic                 w_accept;
    logic                 w_take;
    logic                 w_timeout;

`ifdef FPADD_TIMEOUT_EN
    logic [c_TO_W-1:0]    r_wait_cnt;
    logic                 r_timeout_err;
`endif

    // Later hits overwrite earlier ones, so the search from k=NUM_REQ down
    // to 1 leaves the first valid requester after rr_ptr.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_cand]) begin
                w_grant = w_cand;
                w_any   = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        w_resp_oh  = '0;
        w_sel_a    = '0;
        w_sel_b    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == c_IDX_W'(i)) begin
                w_grant_oh[i] = 1'b1;
                w_sel_a       = req_a[32*i +: 32];
                w_sel_b       = req_b[32*i +: 32];
            end
            if (r_grant == c_IDX_W'(i)) begin
                w_resp_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_take       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            // fpa_done may still be high from the previous operation here.
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                if (fpa_done) begin
                    w_take       = 1'b1;
                    w_state_next = S_RESP;
                end
`ifdef FPADD_TIMEOUT_EN
                else if (r_wait_cnt == c_TO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready[r_grant]) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= c_IDX_W'(NUM_REQ - 1);
            r_grant    <= '0;
            r_fpa_a    <= '0;
            r_fpa_b    <= '0;
            r_rsp_sum  <= '0;
            r_op_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_fpa_a  <= w_sel_a;
                r_fpa_b  <= w_sel_b;
                r_grant  <= w_grant;
                r_rr_ptr <= w_grant;
            end
            if (w_take) begin
                r_rsp_sum  <= fpa_sum;
                r_op_count <= r_op_count + CNT_W'(1);
            end
`ifdef FPADD_TIMEOUT_EN
            if (w_timeout) begin
                r_rsp_sum <= c_QNAN;
            end
`endif
        end
    end

`ifdef FPADD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    // Without the watchdog a timeout can never be raised.
    logic w_unused_timeout;
    assign w_unused_timeout = w_timeout;
`endif

    assign req_ready = (r_state == S_IDLE && w_any) ? w_grant_oh : '0;
    assign rsp_valid = (r_state == S_RESP) ? w_resp_oh : '0;
    assign rsp_sum   = r_rsp_sum;
    assign fpa_start = (r_state == S_ISSUE);
    assign fpa_a     = r_fpa_a;
    assign fpa_b     = r_fpa_b;
    assign busy      = (r_state != S_IDLE);
    assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_fpadd_scheduler.sv
// ============================================================================
// Module   : tb_fpadd_scheduler
// Purpose  : Self-checking bench for fpadd_scheduler with a behavioural adder
//            and an arbitration/counter reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpadd_scheduler;

    localparam int N  = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     rsp_sum;
    logic            fpa_start;
    logic [31:0]     fpa_a;
    logic [31:0]     fpa_b;
    logic [31:0]     fpa_sum;
    logic            fpa_done;
    logic            busy;
    logic [CW-1:0]   op_count;
`ifdef FPADD_TIMEOUT_EN
    logic            timeout_err;
`endif

    fpadd_scheduler #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .fpa_start(fpa_start), .fpa_a(fpa_a), .fpa_b(fpa_b),
        .fpa_sum(fpa_sum), .fpa_done(fpa_done),
        .busy(busy),
`ifdef FPADD_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          exp_ptr;
    int          exp_cnt;
    logic [31:0] a_op [N];
    logic [31:0] b_op [N];
    int          adder_lat = 3;
    bit          adder_dead = 1'b0;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = a_op[i];
            req_b[32*i +: 32] = b_op[i];
        end
    end

    // Normal positive single-precision values only, widened exactly to double.
    function automatic logic [63:0] s2d(input logic [31:0] s);
        logic [10:0] e;
        e = {3'b000, s[30:23]} + 11'd896;
        return {s[31], e, s[22:0], 29'b0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        logic [10:0] e;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        real r;
        r = $bitstoreal(s2d(a)) + $bitstoreal(s2d(b));
        return d2s($realtobits(r));
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        e = 8'(100 + $urandom_range(50));
        return {1'b0, e, 23'($urandom)};
    endfunction

    // Adder: done is a level that drops on start and rises adder_lat edges later.
    int          lat_cnt = 0;
    bit          add_pend = 1'b0;
    logic [31:0] add_a, add_b;
    initial begin
        fpa_done = 1'b0;
        fpa_sum  = 32'h0;
    end
    always @(posedge clk) begin
        if (fpa_start) begin
            fpa_done <= 1'b0;
            lat_cnt  <= adder_lat;
            add_pend <= 1'b1;
            add_a    <= fpa_a;
            add_b    <= fpa_b;
        end else if (add_pend && !adder_dead) begin
            if (lat_cnt <= 1) begin
                fpa_done <= 1'b1;
                fpa_sum  <= fp_add(add_a, add_b);
                add_pend <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int next_grant(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
        end
        return -1;
    endfunction

    // One complete operation, entered during the low phase while IDLE.
    task automatic serve(input bit hold, input int bp, input bit tmo,
                         output int g_out, output logic [31:0] sum_out);
        int          g, n, starts;
        bit          hold_ok;
        logic [31:0] sa, sb, es;
        #1;
        n = 0;
        while (req_ready === '0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        g = next_grant(req_valid);
        g_out = g;
        sum_out = 32'h0;
        check("grant_onehot", req_ready, (g < 0) ? 32'h0 : (32'h1 << g));
        check("ready_same_cycle", n, 0);
        check("idle_not_busy", busy, 0);
        if (g < 0) return;
        sa = a_op[g];
        sb = b_op[g];
        es = tmo ? 32'h7FC0_0000 : fp_add(sa, sb);
        @(posedge clk); #1;
        exp_ptr = g;
        if (hold) begin
            a_op[g] = rand_fp();
            b_op[g] = rand_fp();
        end else begin
            req_valid[g] = 1'b0;
        end
        @(negedge clk);
        check("issue_start", fpa_start, 1);
        check("issue_a", fpa_a, sa);
        check("issue_b", fpa_b, sb);
        check("issue_no_ready", req_ready, 0);
        starts = 1;
        hold_ok = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (fpa_start) starts++;
            if (rsp_valid === '0 && (fpa_a !== sa || fpa_b !== sb || busy !== 1'b1 || req_ready !== '0))
                hold_ok = 1'b0;
        end while (rsp_valid === '0 && n < 200);
        check("rsp_valid_onehot", rsp_valid, 32'h1 << g);
        check("rsp_sum", rsp_sum, es);
        check("one_start_pulse", starts, 1);
        check("wait_hold", hold_ok, 1);
        sum_out = rsp_sum;
        if (!tmo) exp_cnt = (exp_cnt + 1) % (1 << CW);
        check("op_count", op_count, exp_cnt);
`ifdef FPADD_TIMEOUT_EN
        if (tmo) begin
            check("timeout_cycles", n, 65);
            check("timeout_err_pulse", timeout_err, 1);
        end else begin
            check("no_timeout_err", timeout_err, 0);
        end
`endif
        rsp_ready = ~(N'(1) << g);
        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 32'h1 << g);
            check("bp_sum", rsp_sum, es);
            check("bp_busy", busy, 1);
            check("bp_no_ready", req_ready, 0);
`ifdef FPADD_TIMEOUT_EN
            if (c == 0) check("timeout_err_drop", timeout_err, 0);
`endif
        end
        rsp_ready = N'(1) << g;
        @(posedge clk); #1;
        rsp_ready = '0;
        @(negedge clk);
        check("resp_done_valid", rsp_valid, 0);
        check("resp_done_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g;
        logic [31:0] s;
        logic [N-1:0] nv;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            a_op[i] = 32'h0;
            b_op[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_ptr = N - 1;
        exp_cnt = 0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_fpa_start", fpa_start, 0);
        check("rst_fpa_a", fpa_a, 0);
        check("rst_fpa_b", fpa_b, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);

        // 1.0 + 2.0 from requester 0
        a_op[0] = 32'h3F80_0000;
        b_op[0] = 32'h4000_0000;
        req_valid = 4'b0001;
        serve(1'b0, 0, 1'b0, g, s);
        check("single_grant", g, 0);
        check("single_sum", s, 32'h4040_0000);

        // All requesters valid: rotation continues from the last grant
        for (int i = 0; i < N; i++) begin
            a_op[i] = rand_fp();
            b_op[i] = rand_fp();
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            adder_lat = $urandom_range(1, 5);
            serve(1'b1, $urandom_range(0, 3), 1'b0, g, s);
            check("rr_order", g, (k + 1) % N);
        end

        // Long backpressure with others pending
        serve(1'b1, 10, 1'b0, g, s);

        // Stale done left high by the previous operation
        req_valid = '0;
        @(negedge clk);
        a_op[2] = 32'h40A0_0000;
        b_op[2] = 32'h3F80_0000;
        req_valid = 4'b0100;
        adder_lat = 3;
        serve(1'b0, 0, 1'b0, g, s);
        check("stale_sum", s, 32'h40C0_0000);

        // Random traffic, enough to wrap op_count
        for (int k = 0; k < 20; k++) begin
            nv = N'($urandom) & ~req_valid;
            if ((req_valid | nv) == '0) nv = N'(1) << $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++) begin
                if (nv[i]) begin
                    a_op[i] = rand_fp();
                    b_op[i] = rand_fp();
                end
            end
            req_valid = req_valid | nv;
            adder_lat = $urandom_range(1, 6);
            serve(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, g, s);
        end

        // Reset while in WAIT
        req_valid = '0;
        @(negedge clk);
        a_op[1] = rand_fp();
        b_op[1] = rand_fp();
        req_valid = 4'b0010;
        adder_lat = 10;
        #1;
        check("pre_reset_grant", req_ready, 32'h2);
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_ptr = N - 1;
        exp_cnt = 0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_start", fpa_start, 0);
        check("post_rst_op_count", op_count, 0);
        for (int i = 0; i < N; i++) begin
            a_op[i] = rand_fp();
            b_op[i] = rand_fp();
        end
        req_valid = '1;
        adder_lat = 2;
        serve(1'b0, 1, 1'b0, g, s);
        check("post_rst_priority", g, 0);

`ifdef FPADD_TIMEOUT_EN
        // Adder never answers
        req_valid = '0;
        @(negedge clk);
        a_op[3] = rand_fp();
        b_op[3] = rand_fp();
        req_valid = 4'b1000;
        adder_dead = 1'b1;
        serve(1'b0, 2, 1'b1, g, s);
        check("timeout_sum", s, 32'h7FC0_0000);
        adder_dead = 1'b0;
`endif

        req_valid = '0;
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpadd_scheduler.md
Name: fpadd_scheduler

Overview:
- Shares one multi-cycle fpadd unit among NUM_REQ requesters using round-robin arbitration.
- Takes in one operand pair, pulses the adder's start input, waits for done, and returns the sum to the granted requester.
- Sits between client datapaths and the single adder instance. Only one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 16, width of the completed-operation counter.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with FPADD_TIMEOUT_EN).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_a  input  32*NUM_REQ  operand A, requester i at [32*i+31:32*i]
- req_b  input  32*NUM_REQ  operand B, same packing as req_a
- rsp_valid  output  NUM_REQ  one-hot result valid, to the original requester
- rsp_ready  input  NUM_REQ  per-requester result accept
- rsp_sum  output  32  result word, shared by all requesters
- fpa_start  output  1  start pulse to the adder
- fpa_a  output  32  adder operand A
- fpa_b  output  32  adder operand B
- fpa_sum  input  32  adder result
- fpa_done  input  1  adder done (level; cleared by the adder after start)
- busy  output  1  high in any state other than IDLE
- op_count  output  CNT_W  number of completed operations; wraps modulo 2^CNT_W

Behaviour:
- Reset values: state=IDLE; req_ready=0; rsp_valid=0; rsp_sum=0; fpa_start=0; fpa_a=0; fpa_b=0; busy=0; op_count=0; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation: the state returns to IDLE and any in-flight result is discarded. No start pulse is issued in the cycle after reset.
- FSM IDLE:
  - grant = first i with req_valid[i], searching from rr_ptr+1 modulo NUM_REQ.
  - req_ready = onehot(grant), combinational, and only in IDLE.
  - On handshake: register fpa_a/fpa_b from the granted slice, store the grant index, set rr_ptr=grant, go to ISSUE.
  - If no request is valid: req_ready=0 and the FSM stays in IDLE.
- FSM ISSUE:
  - fpa_start=1 for exactly one cycle, then go to WAIT.
  - fpa_done is ignored in this cycle because it may be stale from the previous operation.
- FSM WAIT:
  - fpa_start=0.
  - fpa_a/fpa_b are held stable until the FSM leaves WAIT.
  - When fpa_done=1: register rsp_sum=fpa_sum, set rsp_valid[grant]=1, increment op_count, go to RESP.
- FSM RESP:
  - rsp_valid and rsp_sum are held until rsp_ready[grant]=1; that cycle returns the FSM to IDLE.
  - rsp_ready bits of other requesters are ignored.
- Latency:
  - Request accepted at edge T; fpa_start is high in cycle T+1.
  - Result is visible 1 cycle after the edge at which fpa_done is sampled.
  - Minimum scheduler overhead is 3 cycles plus the adder latency.
- Fairness: a requester granted at edge T has lowest priority at the next arbitration. With all requesters valid, grant order is 0,1,2,3,0,...
- Simultaneous events:
  - A requester may hold req_valid during its own RESP; it is not re-granted before the RESP handshake completes.
  - Requests arriving while busy stay pending; requesters must hold req_valid and operands until req_ready.
- Boundary: op_count wraps from 2^CNT_W-1 to 0 with no flag.

Optional Feature:
- Macro: FPADD_TIMEOUT_EN.
- When defined:
  - Adds output timeout_err (1 bit, reset 0).
  - A WAIT cycle counter is cleared on entry to WAIT.
  - If fpa_done has not been seen after TIMEOUT_CYCLES cycles in WAIT, rsp_sum=32'h7FC00000 (quiet NaN), rsp_valid[grant]=1, timeout_err pulses high for 1 cycle, and the FSM goes to RESP.
  - op_count is not incremented on timeout.
- When not defined: no timeout_err port, and the FSM waits in WAIT indefinitely.

Test Plan:
- Single request, 1.0 + 2.0: req_valid=4'b0001, a=32'h3F800000, b=32'h40000000.
  - Required: req_ready[0] in the same cycle; one fpa_start pulse; rsp_valid=4'b0001 with rsp_sum=32'h40400000; op_count=1.
- All four requesters valid continuously: grant order 0,1,2,3,0 across five operations; exactly one start pulse per operation; each rsp_valid bit matches its requester.
- Backpressure: rsp_ready held 0 for 10 cycles after the result.
  - Required: rsp_valid and rsp_sum stable; no new req_ready; busy=1; completes on the rsp_ready edge.
- Stale done: previous operation left fpa_done=1; launch 32'h40A00000 + 32'h3F800000.
  - Required: the scheduler ignores done in the ISSUE cycle and returns the adder's fresh 32'h40C00000.
- Reset asserted during WAIT: next cycle state=IDLE, rsp_valid=0, fpa_start=0, busy=0; the following request is served normally with priority back at requester 0.
- FPADD_TIMEOUT_EN, adder done tied low: after 64 WAIT cycles, rsp_sum=32'h7FC00000, timeout_err pulses for 1 cycle, op_count unchanged.
